mpq_gen: RTL and testbench
==========================

Name: mpq_gen

Overview:
- Parametrised successor to the fixed 8-bit max priority queue: a binary heap of DEPTH entries, DATA_WIDTH wide, selectable max- or min-ordering.
- Loads unordered data, then executes build, extract, increase-key, insert and RAM-dump commands.
- Extract returns the popped element on a dedicated port.
- Sits between the host data/command interface and the result RAM writer.

Parameters:
DATA_WIDTH, 8, element width in bits
DEPTH, 256, heap capacity in entries (power of 2, 4..256)
ADDR_WIDTH, 8, index/RAM address width, must equal log2(DEPTH)
MIN_HEAP, 0, 0 = max-heap (parent >= children); 1 = min-heap (parent <= children)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
data_valid  in  1  load beat strobe
data  in  DATA_WIDTH  load element
cmd_valid  in  1  command strobe
cmd  in  3  0 build, 1 extract, 2 increase, 3 insert, 4 write_RAM; 5-7 reserved
index  in  ADDR_WIDTH  heap slot for increase
value  in  DATA_WIDTH  new key for increase, element for insert
busy  out  1  high while a command executes
done  out  1  one-cycle pulse at command completion
err  out  1  one-cycle pulse, coincident with done, on a rejected command
ext_valid  out  1  one-cycle pulse carrying an extracted element
ext_data  out  DATA_WIDTH  extracted element, held until next extract
count  out  ADDR_WIDTH+1  current number of entries
RAM_valid  out  1  RAM write strobe
RAM_A  out  ADDR_WIDTH  RAM write address
RAM_D  out  DATA_WIDTH  RAM write data

Behaviour:
- Reset: all outputs 0, count=0, state IDLE. Heap contents are don't-care.
- A reset asserted mid-command aborts the command on the next edge with no done pulse.
- "better(a,b)": a>b when MIN_HEAP=0, a<b when MIN_HEAP=1, unsigned. Ties never swap.
- Load: in IDLE, data_valid with cmd_valid low writes heap[count]=data and increments count. Beats are ignored when count==DEPTH or busy=1.
- Command acceptance: cmd_valid && !busy in IDLE. busy=1 from the next cycle.
- On completion, busy falls and done pulses in the same cycle (last cycle of the DONE state).
- cmd_valid while busy is ignored. data_valid and cmd_valid in the same IDLE cycle: the command wins and the data is dropped.
- States: IDLE, BUILD, DN_CMP, DN_SWP, UP_CMP, UP_SWP, WR_RAM, DONE.
- Sift-down (DN_CMP/DN_SWP), one level per 2 cycles:
  - DN_CMP: l=2i+1, r=2i+2; pick the best of i, l, r among slots < count.
  - DN_SWP: if best!=i, swap, set i=best, return to DN_CMP; else exit to the caller.
- Sift-up (UP_CMP/UP_SWP), one level per 2 cycles: compare i with parent (i-1)>>1; swap while better(heap[i], parent) and i>0.
- build: k runs from (count>>1)-1 down to 0, sift-down each k, then DONE. count<2: DONE directly, with no err.
- extract:
  - count==0: DONE with err=1.
  - Otherwise ext_data=heap[0] and ext_valid pulses the cycle after acceptance.
  - Then heap[0]=heap[count-1], count decrements, sift-down from 0.
- increase ("improve key"):
  - index>=count, or value not better than heap[index] (ties included): err=1, no change.
  - Otherwise write heap[index]=value, then sift-up from index.
- insert:
  - count==DEPTH: err=1, no change.
  - Otherwise heap[count]=value, count increments, sift-up from the old count.
- write_RAM:
  - For a=0..count-1, one word per cycle: RAM_valid=1, RAM_A=a, RAM_D=heap[a]. First word in the cycle after acceptance.
  - done pulses the cycle after the last word.
  - count==0: no writes, done only.
- Reserved cmd: DONE with err=1.
- Worst case for extract/insert/increase: 2 + 2*log2(DEPTH) cycles plus DONE.

Test Plan:
- MAX, load 5,3,9,1,7,2,8,6, build, write_RAM -> RAM words 9,7,8,6,3,2,5,1 at A=0..7; done one cycle after A=7.
- Continue: extract -> ext_data=9, ext_valid pulse, count=7; write_RAM -> 8,7,5,6,3,2,1.
- Continue: insert 10 -> dump 10,8,5,7,3,2,1,6. Increase index 6 to 4 -> dump 10,8,5,7,3,2,4,6. Increase index 5 to 1 -> err pulse, heap unchanged.
- MIN_HEAP=1, load 4,2,3,1, build, write_RAM -> 1,2,3,4. Four extracts -> 1,2,3,4. Fifth extract -> err, count=0.
- DEPTH=4: load 4 values plus a 5th beat -> count=4, 5th beat dropped. insert -> err.
- Assert rst during build (busy=1) -> next cycle busy=0, count=0, RAM_valid=0, no done pulse. A fresh load and build then behave as in the first scenario.

Source files
------------

// File: rtl/mpq_gen.sv
// mpq_gen: parametrised binary max/min heap with build, extract, improve-key, insert and RAM dump
module mpq_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int MIN_HEAP = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  cmd_valid,
    input  logic [2:0]            cmd,
    input  logic [ADDR_WIDTH-1:0] index,
    input  logic [DATA_WIDTH-1:0] value,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  ext_valid,
    output logic [DATA_WIDTH-1:0] ext_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  RAM_valid,
    output logic [ADDR_WIDTH-1:0] RAM_A,
    output logic [DATA_WIDTH-1:0] RAM_D
);
    typedef enum logic [2:0] {IDLE, BUILD, DN_CMP, DN_SWP, UP_CMP, UP_SWP, WR_RAM, DONE} state_t;
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] C1 = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] C2 = (ADDR_WIDTH+1)'(2);
    localparam logic [ADDR_WIDTH-1:0] A1 = ADDR_WIDTH'(1);
    state_t state, state_n;
    logic [DATA_WIDTH-1:0] heap [DEPTH];
    logic [ADDR_WIDTH-1:0] i, k, a, best, b1, dn_best, par;
    logic [ADDR_WIDTH+1:0] l, r;
    logic up_swap, up_hit, from_build, err_r, accept, rej;

    function automatic logic better(input logic [DATA_WIDTH-1:0] x, input logic [DATA_WIDTH-1:0] y);
        return (MIN_HEAP != 0) ? (x < y) : (x > y);
    endfunction

    assign busy = state != IDLE && state != DONE;
    assign done = state == DONE;
    assign err = done && err_r;
    assign RAM_valid = state == WR_RAM;
    assign RAM_A = RAM_valid ? a : '0;
    assign RAM_D = RAM_valid ? heap[a] : '0;

    // child/parent selection and command screening
    always_comb begin
        l = {1'b0, i, 1'b1};
        r = l + (ADDR_WIDTH+2)'(1);
        b1 = (l < {1'b0, count} && better(heap[l[ADDR_WIDTH-1:0]], heap[i])) ? l[ADDR_WIDTH-1:0] : i;
        dn_best = (r < {1'b0, count} && better(heap[r[ADDR_WIDTH-1:0]], heap[b1])) ? r[ADDR_WIDTH-1:0] : b1;
        par = (i - A1) >> 1;
        up_hit = i != '0 && better(heap[i], heap[par]);
        accept = state == IDLE && cmd_valid;
        rej = cmd > 3'd4 || (cmd == 3'd1 && count == '0)
            || (cmd == 3'd2 && ({1'b0, index} >= count || !better(value, heap[index])))
            || (cmd == 3'd3 && count == FULL);
    end

    // next-state selection
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   if (accept) state_n = rej ? DONE : cmd == 3'd0 ? (count < C2 ? DONE : BUILD)
                                        : cmd == 3'd1 ? DN_CMP
                                        : cmd == 3'd4 ? (count == '0 ? DONE : WR_RAM) : UP_CMP;
            BUILD:  state_n = DN_CMP;
            DN_CMP: state_n = DN_SWP;
            DN_SWP: state_n = best != i ? DN_CMP : (from_build && k != '0) ? BUILD : DONE;
            UP_CMP: state_n = UP_SWP;
            UP_SWP: state_n = up_swap ? UP_CMP : DONE;
            WR_RAM: state_n = ({1'b0, a} + C1) == count ? DONE : WR_RAM;
            DONE:   state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    // heap storage, indices and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            ext_valid <= 1'b0;
            ext_data <= '0;
            err_r <= 1'b0;
            from_build <= 1'b0;
            up_swap <= 1'b0;
            i <= '0;
            k <= '0;
            a <= '0;
            best <= '0;
        end else begin
            ext_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        err_r <= rej;
                        from_build <= cmd == 3'd0;
                        a <= '0;
                        k <= ADDR_WIDTH'((count >> 1) - C1);
                        if (!rej && cmd == 3'd1) begin
                            ext_valid <= 1'b1;
                            ext_data <= heap[0];
                            heap[0] <= heap[ADDR_WIDTH'(count - C1)];
                            count <= count - C1;
                            i <= '0;
                        end
                        if (!rej && cmd == 3'd2) begin
                            heap[index] <= value;
                            i <= index;
                        end
                        if (!rej && cmd == 3'd3) begin
                            heap[count[ADDR_WIDTH-1:0]] <= value;
                            count <= count + C1;
                            i <= count[ADDR_WIDTH-1:0];
                        end
                    end else if (data_valid && count != FULL) begin
                        heap[count[ADDR_WIDTH-1:0]] <= data;
                        count <= count + C1;
                    end
                end
                BUILD:  i <= k;
                DN_CMP: best <= dn_best;
                DN_SWP: begin
                    if (best != i) begin
                        heap[i] <= heap[best];
                        heap[best] <= heap[i];
                        i <= best;
                    end else if (from_build && k != '0) k <= k - A1;
                end
                UP_CMP: up_swap <= up_hit;
                UP_SWP: begin
                    if (up_swap) begin
                        heap[i] <= heap[par];
                        heap[par] <= heap[i];
                        i <= par;
                    end
                end
                WR_RAM: a <= a + A1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mpq_gen.sv
// tb_mpq_gen: randomized and directed checks of mpq_gen against a queue-based heap model
module tb_mpq_gen;
    logic clk = 0, rst = 1, data_valid = 0, cmd_valid = 0;
    logic [2:0] cmd = 0;
    logic [7:0] data = 0, index = 0, value = 0;
    int sel = 0;
    logic [2:0] b_o, d_o, e_o, ev_o, rv_o;
    logic [7:0] ed_o [3];
    logic [7:0] rd_o [3];
    logic [4:0] c0;
    logic [3:0] c1, ra0;
    logic [2:0] c2, ra1;
    logic [1:0] ra2;
    logic v_busy, v_done, v_err, v_ev, v_rv;
    logic [7:0] v_ed, v_rd;
    logic [31:0] v_cnt, v_ra;
    int n_cmp = 0, n_fail = 0;
    string rs;
    int nw, ev_n, ev_t, done_t;
    logic [7:0] ev_d;
    bit r_done, r_err, addr_ok, gap_ok, busy_ok;
    int m[$];
    bit mmin;

    always #5 clk = ~clk;

    mpq_gen #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4), .MIN_HEAP(0)) u_max (
        .clk(clk), .rst(rst), .data_valid(data_valid && sel == 0), .data(data),
        .cmd_valid(cmd_valid && sel == 0), .cmd(cmd), .index(index[3:0]), .value(value),
        .busy(b_o[0]), .done(d_o[0]), .err(e_o[0]), .ext_valid(ev_o[0]), .ext_data(ed_o[0]),
        .count(c0), .RAM_valid(rv_o[0]), .RAM_A(ra0), .RAM_D(rd_o[0]));
    mpq_gen #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3), .MIN_HEAP(1)) u_min (
        .clk(clk), .rst(rst), .data_valid(data_valid && sel == 1), .data(data),
        .cmd_valid(cmd_valid && sel == 1), .cmd(cmd), .index(index[2:0]), .value(value),
        .busy(b_o[1]), .done(d_o[1]), .err(e_o[1]), .ext_valid(ev_o[1]), .ext_data(ed_o[1]),
        .count(c1), .RAM_valid(rv_o[1]), .RAM_A(ra1), .RAM_D(rd_o[1]));
    mpq_gen #(.DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2), .MIN_HEAP(0)) u_small (
        .clk(clk), .rst(rst), .data_valid(data_valid && sel == 2), .data(data),
        .cmd_valid(cmd_valid && sel == 2), .cmd(cmd), .index(index[1:0]), .value(value),
        .busy(b_o[2]), .done(d_o[2]), .err(e_o[2]), .ext_valid(ev_o[2]), .ext_data(ed_o[2]),
        .count(c2), .RAM_valid(rv_o[2]), .RAM_A(ra2), .RAM_D(rd_o[2]));

    // view of the currently selected instance
    always_comb begin
        v_busy = b_o[sel];
        v_done = d_o[sel];
        v_err = e_o[sel];
        v_ev = ev_o[sel];
        v_rv = rv_o[sel];
        v_ed = ed_o[sel];
        v_rd = rd_o[sel];
        v_cnt = sel == 0 ? 32'(c0) : sel == 1 ? 32'(c1) : 32'(c2);
        v_ra = sel == 0 ? 32'(ra0) : sel == 1 ? 32'(ra1) : 32'(ra2);
    end

    function automatic bit mbetter(int x, int y);
        return mmin ? x < y : x > y;
    endfunction

    function automatic void mswap(int x, int y);
        int t;
        t = m[x]; m[x] = m[y]; m[y] = t;
    endfunction

    function automatic void msift_down(int i0);
        int i, b, l;
        i = i0;
        while (1) begin
            l = 2 * i + 1;
            b = i;
            if (l < m.size() && mbetter(m[l], m[b])) b = l;
            if (l + 1 < m.size() && mbetter(m[l + 1], m[b])) b = l + 1;
            if (b == i) break;
            mswap(i, b);
            i = b;
        end
    endfunction

    function automatic void msift_up(int i0);
        int i;
        i = i0;
        while (i > 0 && mbetter(m[i], m[(i - 1) / 2])) begin
            mswap(i, (i - 1) / 2);
            i = (i - 1) / 2;
        end
    endfunction

    function automatic string mstr();
        string s;
        s = "";
        foreach (m[j]) s = {s, $sformatf("%0d ", m[j])};
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk); rst = 1;
        @(negedge clk); @(negedge clk); rst = 0;
    endtask

    task automatic load(input int v);
        @(negedge clk); data_valid = 1; data = v[7:0];
        @(negedge clk); data_valid = 0;
    endtask

    task automatic run_cmd(input int c, input int idx, input int val, input bit dv);
        bit prev_rv;
        @(negedge clk); cmd_valid = 1; cmd = c[2:0]; index = idx[7:0]; value = val[7:0];
        if (dv) begin data_valid = 1; data = 8'd99; end
        @(negedge clk); cmd_valid = 0; data_valid = 0;
        rs = ""; nw = 0; ev_n = 0; ev_t = -1; done_t = -1; ev_d = 0;
        r_done = 0; r_err = 0; addr_ok = 1; gap_ok = 0; busy_ok = 1; prev_rv = 0;
        for (int t = 0; t < 400 && !r_done; t++) begin
            if (t > 0) @(negedge clk);
            if (v_rv) begin
                if (v_ra != 32'(nw)) addr_ok = 0;
                rs = {rs, $sformatf("%0d ", v_rd)};
                nw++;
            end
            if (v_ev) begin ev_n++; ev_d = v_ed; ev_t = t; end
            if (v_busy == v_done) busy_ok = 0;
            if (v_done) begin r_done = 1; r_err = v_err; done_t = t; gap_ok = nw == 0 || prev_rv; end
            prev_rv = v_rv;
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            @(negedge clk);
            n_cmp++;
            if ({v_busy, v_done, v_err, v_ev, v_rv} !== 5'd0 || v_ed !== 8'd0 || v_cnt !== 0 || v_ra !== 0 || v_rd !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got busy=%b done=%b err=%b ev=%b ed=%0d cnt=%0d rv=%b ra=%0d rd=%0d, want all 0",
                         s, v_busy, v_done, v_err, v_ev, v_ed, v_cnt, v_rv, v_ra, v_rd);
            end
        end
    endtask

    task automatic test_plan_max();
        int vals[8] = '{5, 3, 9, 1, 7, 2, 8, 6};
        sel = 0; do_reset();
        foreach (vals[j]) load(vals[j]);
        run_cmd(0, 0, 0, 0);
        n_cmp++;
        if (!r_done || r_err) begin n_fail++; $display("FAIL plan_build: done=%b err=%b, want done=1 err=0", r_done, r_err); end
        run_cmd(4, 0, 0, 0);
        n_cmp++;
        if (rs != "9 7 8 6 3 2 5 1 " || !addr_ok || !gap_ok || !busy_ok) begin
            n_fail++; $display("FAIL plan_dump: got '%s' addr_ok=%b gap_ok=%b busy_ok=%b, want '9 7 8 6 3 2 5 1 ' 1 1 1", rs, addr_ok, gap_ok, busy_ok);
        end
        run_cmd(1, 0, 0, 0);
        n_cmp++;
        if (!r_done || r_err || ev_n != 1 || ev_d !== 8'd9 || ev_t != 0 || v_cnt !== 7) begin
            n_fail++; $display("FAIL plan_extract: got ev_n=%0d ev_d=%0d ev_t=%0d cnt=%0d err=%b, want 1 9 0 7 0", ev_n, ev_d, ev_t, v_cnt, r_err);
        end
        run_cmd(4, 0, 0, 0);
        n_cmp++;
        if (rs != "8 7 5 6 3 2 1 ") begin n_fail++; $display("FAIL plan_dump_ext: got '%s' want '8 7 5 6 3 2 1 '", rs); end
        run_cmd(3, 0, 10, 0);
        run_cmd(4, 0, 0, 0);
        n_cmp++;
        if (rs != "10 8 5 7 3 2 1 6 ") begin n_fail++; $display("FAIL plan_insert: got '%s' want '10 8 5 7 3 2 1 6 '", rs); end
        run_cmd(2, 6, 4, 0);
        n_cmp++;
        if (!r_done || r_err) begin n_fail++; $display("FAIL plan_increase_ok: done=%b err=%b, want 1 0", r_done, r_err); end
        run_cmd(4, 0, 0, 0);
        n_cmp++;
        if (rs != "10 8 5 7 3 2 4 6 ") begin n_fail++; $display("FAIL plan_increase: got '%s' want '10 8 5 7 3 2 4 6 '", rs); end
        run_cmd(2, 5, 1, 0);
        n_cmp++;
        if (!r_done || !r_err) begin n_fail++; $display("FAIL plan_increase_worse: done=%b err=%b, want 1 1", r_done, r_err); end
        run_cmd(2, 0, 10, 0);
        n_cmp++;
        if (!r_done || !r_err) begin n_fail++; $display("FAIL plan_increase_tie: done=%b err=%b, want 1 1", r_done, r_err); end
        run_cmd(2, 9, 200, 0);
        n_cmp++;
        if (!r_done || !r_err) begin n_fail++; $display("FAIL plan_increase_range: done=%b err=%b, want 1 1", r_done, r_err); end
        run_cmd(4, 0, 0, 0);
        n_cmp++;
        if (rs != "10 8 5 7 3 2 4 6 ") begin n_fail++; $display("FAIL plan_unchanged: got '%s' want '10 8 5 7 3 2 4 6 '", rs); end
    endtask

    task automatic test_min();
        int vals[4] = '{4, 2, 3, 1};
        sel = 1; do_reset();
        foreach (vals[j]) load(vals[j]);
        run_cmd(0, 0, 0, 0);
        run_cmd(4, 0, 0, 0);
        n_cmp++;
        if (rs != "1 2 3 4 ") begin n_fail++; $display("FAIL min_dump: got '%s' want '1 2 3 4 '", rs); end
        for (int e = 1; e <= 4; e++) begin
            run_cmd(1, 0, 0, 0);
            n_cmp++;
            if (!r_done || r_err || ev_n != 1 || ev_d !== 8'(e)) begin
                n_fail++; $display("FAIL min_extract%0d: got ev_n=%0d ev_d=%0d err=%b, want 1 %0d 0", e, ev_n, ev_d, r_err, e);
            end
        end
        run_cmd(1, 0, 0, 0);
        n_cmp++;
        if (!r_done || !r_err || ev_n != 0 || v_cnt !== 0 || done_t != 0) begin
            n_fail++; $display("FAIL min_extract_empty: got err=%b ev_n=%0d cnt=%0d done_t=%0d, want 1 0 0 0", r_err, ev_n, v_cnt, done_t);
        end
    endtask

    task automatic test_small();
        sel = 2; do_reset();
        for (int j = 1; j <= 5; j++) load(11 * j);
        n_cmp++;
        if (v_cnt !== 4) begin n_fail++; $display("FAIL small_full_count: got %0d want 4", v_cnt); end
        run_cmd(3, 0, 7, 0);
        n_cmp++;
        if (!r_done || !r_err) begin n_fail++; $display("FAIL small_insert_full: done=%b err=%b, want 1 1", r_done, r_err); end
        run_cmd(4, 0, 0, 0);
        n_cmp++;
        if (rs != "11 22 33 44 ") begin n_fail++; $display("FAIL small_dump: got '%s' want '11 22 33 44 '", rs); end
        run_cmd(6, 0, 0, 0);
        n_cmp++;
        if (!r_done || !r_err || done_t != 0) begin n_fail++; $display("FAIL small_reserved: done=%b err=%b t=%0d, want 1 1 0", r_done, r_err, done_t); end
        do_reset();
        run_cmd(4, 0, 0, 0);
        n_cmp++;
        if (!r_done || r_err || nw != 0 || done_t != 0) begin
            n_fail++; $display("FAIL small_empty_dump: done=%b err=%b words=%0d t=%0d, want 1 0 0 0", r_done, r_err, nw, done_t);
        end
        for (int j = 1; j <= 3; j++) load(11 * j);
        run_cmd(4, 0, 0, 1);
        n_cmp++;
        if (rs != "11 22 33 " || v_cnt !== 3) begin n_fail++; $display("FAIL small_cmd_wins: got '%s' cnt=%0d, want '11 22 33 ' 3", rs, v_cnt); end
    endtask

    task automatic test_reset_mid();
        int vals[8] = '{5, 3, 9, 1, 7, 2, 8, 6};
        bit seen;
        sel = 0; do_reset();
        foreach (vals[j]) load(vals[j]);
        @(negedge clk); cmd_valid = 1; cmd = 0;
        @(negedge clk); cmd_valid = 0;
        @(negedge clk);
        n_cmp++;
        if (v_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", v_busy); end
        rst = 1;
        @(negedge clk);
        rst = 0;
        n_cmp++;
        if (v_busy !== 1'b0 || v_cnt !== 0 || v_rv !== 1'b0 || v_done !== 1'b0) begin
            n_fail++; $display("FAIL mid_abort: got busy=%b cnt=%0d rv=%b done=%b, want 0 0 0 0", v_busy, v_cnt, v_rv, v_done);
        end
        seen = 0;
        repeat (20) begin @(negedge clk); if (v_done) seen = 1; end
        n_cmp++;
        if (seen) begin n_fail++; $display("FAIL mid_no_done: got done pulse=1 want 0"); end
        foreach (vals[j]) load(vals[j]);
        run_cmd(0, 0, 0, 0);
        run_cmd(4, 0, 0, 0);
        n_cmp++;
        if (rs != "9 7 8 6 3 2 5 1 ") begin n_fail++; $display("FAIL mid_rebuild: got '%s' want '9 7 8 6 3 2 5 1 '", rs); end
    endtask

    task automatic test_random();
        int n, op, idx, val, e_ext;
        bit e_err;
        sel = 0; mmin = 0; do_reset();
        m.delete();
        n = $urandom_range(1, 16);
        repeat (n) begin val = $urandom_range(0, 31); load(val); m.push_back(val); end
        run_cmd(0, 0, 0, 0);
        for (int k = m.size() / 2 - 1; k >= 0; k--) msift_down(k);
        run_cmd(4, 0, 0, 0);
        n_cmp++;
        if (rs != mstr()) begin n_fail++; $display("FAIL rand_build: got '%s' want '%s'", rs, mstr()); end
        for (int s = 0; s < 40; s++) begin
            op = $urandom_range(1, 3); idx = $urandom_range(0, 15); val = $urandom_range(0, 31);
            e_err = 0; e_ext = -1;
            if (op == 1) begin
                if (m.size() == 0) e_err = 1;
                else begin e_ext = m[0]; m[0] = m[m.size() - 1]; m.pop_back(); msift_down(0); end
            end else if (op == 2) begin
                if (idx >= m.size() || !mbetter(val, m[idx])) e_err = 1;
                else begin m[idx] = val; msift_up(idx); end
            end else begin
                if (m.size() == 16) e_err = 1;
                else begin m.push_back(val); msift_up(m.size() - 1); end
            end
            run_cmd(op, idx, val, 0);
            n_cmp++;
            if (!r_done || r_err != e_err || v_cnt !== 32'(m.size())
                || (e_ext >= 0 && (ev_n != 1 || ev_d !== 8'(e_ext) || ev_t != 0)) || (e_ext < 0 && ev_n != 0)) begin
                n_fail++;
                $display("FAIL rand_op%0d(cmd=%0d idx=%0d val=%0d): got done=%b err=%b cnt=%0d ev_n=%0d ev_d=%0d, want err=%b cnt=%0d ext=%0d",
                         s, op, idx, val, r_done, r_err, v_cnt, ev_n, ev_d, e_err, m.size(), e_ext);
            end
            run_cmd(4, 0, 0, 0);
            n_cmp++;
            if (rs != mstr() || !addr_ok || !gap_ok) begin
                n_fail++; $display("FAIL rand_dump%0d: got '%s' addr_ok=%b gap_ok=%b want '%s'", s, rs, addr_ok, gap_ok, mstr());
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst = 0;
        test_plan_max();
        test_min();
        test_small();
        test_reset_mid();
        repeat (3) test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
